// File: rtl/pe_pkg.sv
// Shared PE feeder constants and FSM state encoding.
// Imported by the feeder, its row registers and the bench.
package pe_pkg;
  localparam int DW = 16;
  localparam int FN = 3;
  localparam int PN = 5;
  localparam int IN = FN + PN - 1;
  localparam int IDXW = (IN > 1) ? $clog2(IN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_F,
    ST_LOAD_I,
    ST_LOAD_P,
    ST_FIRE,
    ST_WAIT
  } state_t;
endpackage

// File: rtl/pe_row_reg.sv
// Indexed write-enable register row; one word written per cycle at idx.
// Zero latency to row_q after the write edge; no backpressure.
module pe_row_reg #(
  parameter int DW    = pe_pkg::DW,
  parameter int DEPTH = pe_pkg::FN,
  parameter int IW    = pe_pkg::IDXW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [IW-1:0]               idx,
  input  logic [DW-1:0]               din,
  output logic [DEPTH-1:0][DW-1:0]    row_q
);
  import pe_pkg::*;

  logic [DEPTH-1:0][DW-1:0] row_d;

  always_comb begin
    row_d = row_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (idx == IW'(i))) begin
        row_d[i] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/pe_feeder.sv
// Serially loads filter/ifmap/psum rows, pulses EN, then waits for PE_DONE.
// IN_READY high only in LOAD states; IN_VALID=0 stalls the load without data change.
module pe_feeder #(
  parameter int DW = pe_pkg::DW,
  parameter int FN = pe_pkg::FN,
  parameter int PN = pe_pkg::PN,
  localparam int IN = FN + PN - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  KEEP_FILTER,
  output logic [FN-1:0][DW-1:0] FILTER_OUT,
  output logic [IN-1:0][DW-1:0] DATA_OUT,
  output logic [PN-1:0][DW-1:0] PSUM_OUT,
  output logic                  EN,
  input  logic                  PE_DONE,
  output logic                  BUSY,
  output logic [15:0]           PASS_CNT
);
  import pe_pkg::*;

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IW-1:0] F_LAST = IW'(FN - 1);
  localparam logic [IW-1:0] I_LAST = IW'(IN - 1);
  localparam logic [IW-1:0] P_LAST = IW'(PN - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          floaded_q, floaded_d;
  logic [15:0]   pass_q, pass_d;
  logic          en_q, en_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          accept;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    floaded_d = floaded_q;
    pass_d    = pass_q;
    accept    = IN_VALID && in_ready_q;
    case (state_q)
      ST_IDLE: begin
        // Entry only; the word on the bus is taken in the first LOAD cycle.
        if (IN_VALID) begin
          state_d = (KEEP_FILTER && floaded_q) ? ST_LOAD_I : ST_LOAD_F;
          idx_d   = '0;
        end
      end
      ST_LOAD_F: begin
        if (accept) begin
          if (idx_q == F_LAST) begin
            state_d   = ST_LOAD_I;
            idx_d     = '0;
            floaded_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_LOAD_I: begin
        if (accept) begin
          if (idx_q == I_LAST) begin
            state_d = ST_LOAD_P;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_LOAD_P: begin
        if (accept) begin
          if (idx_q == P_LAST) begin
            state_d = ST_FIRE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (PE_DONE) begin
          state_d = ST_IDLE;
          pass_d  = pass_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    en_d       = (state_d == ST_FIRE);
    in_ready_d = (state_d == ST_LOAD_F) || (state_d == ST_LOAD_I) || (state_d == ST_LOAD_P);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      floaded_q  <= 1'b0;
      pass_q     <= '0;
      en_q       <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      floaded_q  <= floaded_d;
      pass_q     <= pass_d;
      en_q       <= en_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  pe_row_reg #(.DW(DW), .DEPTH(FN), .IW(IW)) u_filter (
    .clk(clk), .rst(rst), .we(accept && (state_q == ST_LOAD_F)),
    .idx(idx_q), .din(IN_DATA), .row_q(FILTER_OUT)
  );

  pe_row_reg #(.DW(DW), .DEPTH(IN), .IW(IW)) u_ifmap (
    .clk(clk), .rst(rst), .we(accept && (state_q == ST_LOAD_I)),
    .idx(idx_q), .din(IN_DATA), .row_q(DATA_OUT)
  );

  pe_row_reg #(.DW(DW), .DEPTH(PN), .IW(IW)) u_psum (
    .clk(clk), .rst(rst), .we(accept && (state_q == ST_LOAD_P)),
    .idx(idx_q), .din(IN_DATA), .row_q(PSUM_OUT)
  );

  assign EN       = en_q;
  assign IN_READY = in_ready_q;
  assign BUSY     = busy_q;
  assign PASS_CNT = pass_q;
endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: randomized passes against a row-level reference model,
// expected rows queued per pass and checked by a monitor on each EN pulse.
module tb_pe_feeder;
  import pe_pkg::*;

  localparam int NW = FN + IN + PN;

  typedef logic [FN-1:0][DW-1:0] frow_t;
  typedef logic [IN-1:0][DW-1:0] drow_t;
  typedef logic [PN-1:0][DW-1:0] prow_t;
  typedef struct {
    frow_t f;
    drow_t d;
    prow_t p;
    int    en_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic          KEEP_FILTER;
  frow_t         FILTER_OUT;
  drow_t         DATA_OUT;
  prow_t         PSUM_OUT;
  logic          EN;
  logic          PE_DONE;
  logic          BUSY;
  logic [15:0]   PASS_CNT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic en_prev = 1'b0;

  exp_t          sb[$];
  frow_t         m_filt;
  drow_t         m_data;
  prow_t         m_psum;
  bit            m_loaded;
  logic [15:0]   m_pass;
  logic [DW-1:0] stream [NW];

  pe_feeder dut (
    .clk(clk), .rst(rst), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .KEEP_FILTER(KEEP_FILTER), .FILTER_OUT(FILTER_OUT), .DATA_OUT(DATA_OUT),
    .PSUM_OUT(PSUM_OUT), .EN(EN), .PE_DONE(PE_DONE), .BUSY(BUSY), .PASS_CNT(PASS_CNT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: each EN pulse must match the oldest queued pass.
  always @(negedge clk) begin
    if (!rst && EN) begin
      if (en_prev) chk("en_one_cycle", 128'(en_prev), 128'(0));
      if (sb.size() == 0) begin
        chk("en_unexpected", 128'(EN), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("en_cycle", 128'(cyc), 128'(e.en_cyc));
        chk("filter_out", 128'(FILTER_OUT), 128'(e.f));
        chk("data_out", 128'(DATA_OUT), 128'(e.d));
        chk("psum_out", 128'(PSUM_OUT), 128'(e.p));
        chk("fire_busy", 128'(BUSY), 128'(1));
        chk("fire_rdy", 128'(IN_READY), 128'(0));
      end
    end
    en_prev = rst ? 1'b0 : EN;
  end

  task automatic fill_stream(input bit spec);
    logic [DW-1:0] sp [NW];
    sp = '{16'hFEDD, 16'hFFBC, 16'hFCFD, 16'h0C8C, 16'h0FDF, 16'h0FCF, 16'h0FCF, 16'h0D6D,
           16'h0A8A, 16'h0A8A, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < NW; i++) stream[i] = spec ? sp[i] : DW'($urandom);
  endtask

  // Reset is applied with IN_VALID and PE_DONE high to show it takes priority.
  task automatic do_reset();
    rst = 1'b1; IN_VALID = 1'b1; PE_DONE = 1'b1; IN_DATA = DW'($urandom);
    @(posedge clk); #1;
    rst = 1'b0; IN_VALID = 1'b0; PE_DONE = 1'b0;
    m_filt = '0; m_data = '0; m_psum = '0; m_loaded = 1'b0; m_pass = '0;
    @(negedge clk);
    chk("rst_filter", 128'(FILTER_OUT), 128'(0));
    chk("rst_data", 128'(DATA_OUT), 128'(0));
    chk("rst_psum", 128'(PSUM_OUT), 128'(0));
    chk("rst_pass_cnt", 128'(PASS_CNT), 128'(0));
    chk("rst_en", 128'(EN), 128'(0));
    chk("rst_busy", 128'(BUSY), 128'(0));
    chk("rst_rdy", 128'(IN_READY), 128'(0));
  endtask

  // mode: 0 gapless, 1 valid toggling 0/1, 2 random gaps. abort_at>0 resets after that many words.
  task automatic run_pass(input bit keep, input int mode, input int abort_at, input bit hold_done);
    logic [DW-1:0] w[$];
    bit need_f;
    int c, idx, len, nw, off;
    bit v;
    exp_t e;
    need_f = !(keep && m_loaded);
    for (int i = 0; i < NW; i++) if (need_f || i >= FN) w.push_back(stream[i]);

    @(posedge clk); #1;
    c = cyc;
    KEEP_FILTER = keep; PE_DONE = hold_done; IN_VALID = 1'b1; IN_DATA = w[0];
    @(negedge clk);
    chk("idle_rdy", 128'(IN_READY), 128'(0));
    chk("idle_busy", 128'(BUSY), 128'(0));
    @(posedge clk); #1;

    idx = 0; len = 0;
    while (idx < w.size()) begin
      len++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((len % 2) == 0) : ($urandom_range(0, 2) != 0);
      IN_VALID = v;
      IN_DATA = v ? w[idx] : DW'($urandom);
      KEEP_FILTER = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("load_rdy", 128'(IN_READY), 128'(1));
      chk("load_busy", 128'(BUSY), 128'(1));
      @(posedge clk);
      if (v) idx++;
      #1;
      if (abort_at > 0 && idx == abort_at) begin
        do_reset();
        return;
      end
    end
    IN_VALID = 1'b0; KEEP_FILTER = 1'b0;

    if (need_f) for (int i = 0; i < FN; i++) m_filt[i] = w[i];
    off = need_f ? FN : 0;
    for (int i = 0; i < IN; i++) m_data[i] = w[off + i];
    for (int i = 0; i < PN; i++) m_psum[i] = w[off + IN + i];
    m_loaded = 1'b1;
    e.f = m_filt; e.d = m_data; e.p = m_psum; e.en_cyc = c + len + 1;
    sb.push_back(e);

    @(posedge clk); #1;
    nw = hold_done ? 0 : $urandom_range(0, 3);
    repeat (nw) begin
      IN_VALID = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wait_busy", 128'(BUSY), 128'(1));
      chk("wait_rdy", 128'(IN_READY), 128'(0));
      @(posedge clk); #1;
    end
    IN_VALID = 1'b0;
    @(negedge clk);
    chk("wait_busy", 128'(BUSY), 128'(1));
    chk("pass_before_done", 128'(PASS_CNT), 128'(m_pass));
    PE_DONE = 1'b1;
    @(posedge clk); #1;
    PE_DONE = hold_done;
    m_pass++;
    if (hold_done) begin
      repeat (2) @(posedge clk);
      #1; PE_DONE = 1'b0;
    end
    @(negedge clk);
    chk("pass_cnt", 128'(PASS_CNT), 128'(m_pass));
    chk("done_busy", 128'(BUSY), 128'(0));
    chk("done_en", 128'(EN), 128'(0));
    chk("hold_filter", 128'(FILTER_OUT), 128'(m_filt));
    chk("hold_data", 128'(DATA_OUT), 128'(m_data));
    chk("hold_psum", 128'(PSUM_OUT), 128'(m_psum));
    chk("en_seen", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; KEEP_FILTER = 1'b0; PE_DONE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    fill_stream(1); run_pass(0, 0, 0, 0);
    fill_stream(0); run_pass(1, 0, 0, 0);
    chk("two_passes", 128'(PASS_CNT), 128'(2));
    fill_stream(1); run_pass(0, 1, 0, 0);
    fill_stream(0); run_pass(0, 0, 9, 0);
    fill_stream(0); run_pass(0, 0, 0, 0);
    do_reset();
    fill_stream(0); run_pass(1, 2, 0, 0);
    fill_stream(0); run_pass(1, 2, 0, 0);
    fill_stream(0); run_pass(0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      fill_stream(0);
      run_pass(1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
